riscv_boot_ctrl: RTL and testbench

Load-and-run controller for the `riscv32` core. It accepts a byte stream over a valid/ready handshake and decodes load commands into byte writes to instruction memory or word writes to data memory. It decodes run commands into a bounded `core_start` window with cycle counting, halt detection and timeout. It sits between a host/debug link and the `riscv_datapath` memories and start input, and it replaces hierarchical memory preloading.

---
 rtl/riscv_boot_ctrl.sv | 156 +++++++++++++++
 tb/tb_riscv_boot_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_boot_ctrl.sv
// rtl/riscv_boot_ctrl.sv - byte-stream load-and-run controller for the riscv32 core
// Decodes IMEM/DMEM load frames into memory writes and RUN frames into a bounded core_start window.
module riscv_boot_ctrl #(
  parameter int IMEM_AW = 10,
  parameter int DMEM_AW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  input  logic [7:0]         s_data,
  output logic               s_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [7:0]         imem_wdata,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  output logic               core_start,
  input  logic               core_halt,
  input  logic               abort,
  output logic               busy,
  output logic               run_done,
  output logic               run_halted,
  output logic               err,
  output logic [31:0]        cycle_count
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR_H, ST_ADDR_L, ST_LEN_H, ST_LEN_L, ST_PAYLOAD,
    ST_MAX0, ST_MAX1, ST_MAX2, ST_MAX3, ST_RUN
  } state_t;

  state_t             r_state;
  logic               r_is_dmem;
  logic [7:0]         r_ahi;
  logic [7:0]         r_lhi;
  logic [15:0]        r_len;
  logic [IMEM_AW-1:0] r_iptr;
  logic [DMEM_AW-1:0] r_dptr;
  logic [23:0]        r_shift;
  logic [1:0]         r_bcnt;
  logic [31:0]        r_max;

  logic        w_accept;
  logic [15:0] w_len;
  logic [31:0] w_cnt_inc;
  logic        w_timeout;

  assign s_ready   = (r_state != ST_RUN);
  assign busy      = (r_state != ST_IDLE);
  assign w_accept  = s_valid && s_ready;
  assign w_len     = {r_lhi, s_data};
  assign w_cnt_inc = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
  assign w_timeout = (r_max != 32'd0) && (w_cnt_inc == r_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_is_dmem   <= 1'b0;
      r_ahi       <= 8'h00;
      r_lhi       <= 8'h00;
      r_len       <= 16'h0000;
      r_iptr      <= '0;
      r_dptr      <= '0;
      r_shift     <= 24'h000000;
      r_bcnt      <= 2'd0;
      r_max       <= 32'd0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= 8'h00;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= 32'd0;
      core_start  <= 1'b0;
      run_done    <= 1'b0;
      run_halted  <= 1'b0;
      err         <= 1'b0;
      cycle_count <= 32'd0;
    end else begin
      imem_we  <= 1'b0;
      dmem_we  <= 1'b0;
      run_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          case (s_data)
            8'h01: begin r_is_dmem <= 1'b0; err <= 1'b0; r_state <= ST_ADDR_H; end
            8'h02: begin r_is_dmem <= 1'b1; err <= 1'b0; r_state <= ST_ADDR_H; end
            8'h03: begin err <= 1'b0; r_state <= ST_MAX0; end
            default: err <= 1'b1;
          endcase
        end
        ST_ADDR_H: if (w_accept) begin
          r_ahi   <= s_data;
          r_state <= ST_ADDR_L;
        end
        ST_ADDR_L: if (w_accept) begin
          r_iptr  <= IMEM_AW'({r_ahi, s_data});
          r_dptr  <= DMEM_AW'({r_ahi, s_data});
          r_state <= ST_LEN_H;
        end
        ST_LEN_H: if (w_accept) begin
          r_lhi   <= s_data;
          r_state <= ST_LEN_L;
        end
        ST_LEN_L: if (w_accept) begin
          r_len   <= w_len;
          r_bcnt  <= 2'd0;
          r_state <= (w_len == 16'd0) ? ST_IDLE : ST_PAYLOAD;
        end
        ST_PAYLOAD: if (w_accept) begin
          if (!r_is_dmem) begin
            imem_we    <= 1'b1;
            imem_addr  <= r_iptr;
            imem_wdata <= s_data;
            r_iptr     <= r_iptr + IMEM_AW'(1);
            r_len      <= r_len - 16'd1;
            if (r_len == 16'd1) r_state <= ST_IDLE;
          end else begin
            // Words arrive MSB first; the fourth byte completes and commits the word.
            r_shift <= {r_shift[15:0], s_data};
            r_bcnt  <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              dmem_we    <= 1'b1;
              dmem_addr  <= r_dptr;
              dmem_wdata <= {r_shift, s_data};
              r_dptr     <= r_dptr + DMEM_AW'(1);
              r_len      <= r_len - 16'd1;
              if (r_len == 16'd1) r_state <= ST_IDLE;
            end
          end
        end
        ST_MAX0: if (w_accept) begin r_max <= {r_max[23:0], s_data}; r_state <= ST_MAX1; end
        ST_MAX1: if (w_accept) begin r_max <= {r_max[23:0], s_data}; r_state <= ST_MAX2; end
        ST_MAX2: if (w_accept) begin r_max <= {r_max[23:0], s_data}; r_state <= ST_MAX3; end
        ST_MAX3: if (w_accept) begin
          r_max       <= {r_max[23:0], s_data};
          cycle_count <= 32'd0;
          core_start  <= 1'b1;
          r_state     <= ST_RUN;
        end
        ST_RUN: begin
          // The count includes the current cycle, so an end event here leaves it equal to cycles run.
          cycle_count <= w_cnt_inc;
          if (core_halt || abort || w_timeout) begin
            core_start <= 1'b0;
            run_done   <= 1'b1;
            run_halted <= core_halt;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// tb/tb_riscv_boot_ctrl.sv - directed self-checking bench for riscv_boot_ctrl
module tb_riscv_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [7:0]  imem_wdata;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic        core_start;
  logic        core_halt = 1'b0;
  logic        abort = 1'b0;
  logic        busy;
  logic        run_done;
  logic        run_halted;
  logic        err;
  logic [31:0] cycle_count;

  riscv_boot_ctrl #(.IMEM_AW(10), .DMEM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .core_start(core_start), .core_halt(core_halt), .abort(abort), .busy(busy),
    .run_done(run_done), .run_halted(run_halted), .err(err), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [31:0] iw_a[$], iw_d[$], dw_a[$], dw_d[$];
  int iw_c[$];
  logic [7:0] frame[$];
  int hi_cnt;
  bit ready_seen, done_seen;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rst_n) begin
    if (imem_we) begin iw_a.push_back(32'(imem_addr)); iw_d.push_back(32'(imem_wdata)); iw_c.push_back(cyc); end
    if (dmem_we) begin dw_a.push_back(32'(dmem_addr)); dw_d.push_back(dmem_wdata); end
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit gaps);
    foreach (frame[i]) begin
      send(frame[i]);
      if (gaps) idle(1);
    end
  endtask

  task automatic clear_logs();
    iw_a.delete(); iw_d.delete(); iw_c.delete(); dw_a.delete(); dw_d.delete();
  endtask

  // Drives halt/abort so they are sampled at the edge that brings cycle_count to ev_at.
  task automatic run_watch(input int ev_at, input bit do_halt, input bit do_abort);
    s_valid = 1'b0;
    hi_cnt = 0; ready_seen = 1'b0; done_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (run_done) begin done_seen = 1'b1; break; end
      if (core_start) begin
        hi_cnt++;
        if (s_ready) ready_seen = 1'b1;
      end
      if (ev_at > 0 && cycle_count == 32'(ev_at - 1) && core_start) begin
        core_halt = do_halt;
        abort     = do_abort;
      end else begin
        core_halt = 1'b0;
        abort     = 1'b0;
      end
      @(negedge clk);
    end
    core_halt = 1'b0;
    abort     = 1'b0;
    expect_eq("run_done_seen", 32'(done_seen), 1);
    expect_eq("busy_at_done", 32'(busy), 0);
    expect_eq("start_at_done", 32'(core_start), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach summary");
    $fatal(1);
  end

  initial begin
    logic [7:0] prog[12];
    prog = '{8'h00, 8'h00, 8'h81, 8'h33, 8'h00, 8'h00, 8'hA1, 8'h83, 8'h00, 8'h21, 8'h84, 8'h63};

    repeat (2) @(negedge clk);
    expect_eq("rst_s_ready", 32'(s_ready), 1);
    expect_eq("rst_busy", 32'(busy), 0);
    expect_eq("rst_core_start", 32'(core_start), 0);
    expect_eq("rst_imem_we", 32'(imem_we), 0);
    expect_eq("rst_dmem_we", 32'(dmem_we), 0);
    expect_eq("rst_cycle_count", cycle_count, 0);
    expect_eq("rst_err", 32'(err), 0);
    expect_eq("rst_dmem_wdata", dmem_wdata, 0);
    rst_n = 1'b1;
    idle(2);

    frame = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h81, 8'h33,
              8'h00, 8'h00, 8'hA1, 8'h83, 8'h00, 8'h21, 8'h84, 8'h63};
    send_frame(1'b0);
    idle(3);
    expect_eq("imem_count", 32'(iw_a.size()), 12);
    if (iw_a.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        expect_eq($sformatf("imem_addr%0d", i), iw_a[i], 32'(i));
        expect_eq($sformatf("imem_data%0d", i), iw_d[i], 32'(prog[i]));
      end
      expect_eq("imem_b2b_span", 32'(iw_c[11] - iw_c[0]), 11);
    end
    expect_eq("imem_busy_after", 32'(busy), 0);
    clear_logs();

    frame = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    send_frame(1'b0);
    idle(3);
    expect_eq("dmem_count", 32'(dw_a.size()), 1);
    expect_eq("imem_none_on_dmem", 32'(iw_a.size()), 0);
    if (dw_a.size() == 1) begin
      expect_eq("dmem_addr", dw_a[0], 1);
      expect_eq("dmem_data", dw_d[0], 32'h0000_0002);
    end
    clear_logs();

    frame = '{8'h02, 8'h00, 8'hFF, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    send_frame(1'b1);
    idle(3);
    expect_eq("dmem_wrap_count", 32'(dw_a.size()), 2);
    if (dw_a.size() == 2) begin
      expect_eq("dmem_wrap_a0", dw_a[0], 32'h0FF);
      expect_eq("dmem_wrap_d0", dw_d[0], 32'hDEAD_BEEF);
      expect_eq("dmem_wrap_a1", dw_a[1], 32'h000);
      expect_eq("dmem_wrap_d1", dw_d[1], 32'h0123_4567);
    end
    clear_logs();

    send(8'h55);
    idle(3);
    expect_eq("bad_cmd_err", 32'(err), 1);
    expect_eq("bad_cmd_busy", 32'(busy), 0);
    expect_eq("bad_cmd_no_write", 32'(iw_a.size() + dw_a.size()), 0);
    frame = '{8'h01, 8'h03, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hBB};
    send_frame(1'b0);
    idle(3);
    expect_eq("err_cleared", 32'(err), 0);
    expect_eq("iwrap_count", 32'(iw_a.size()), 2);
    if (iw_a.size() == 2) begin
      expect_eq("iwrap_a0", iw_a[0], 32'h3FF);
      expect_eq("iwrap_d0", iw_d[0], 32'hAA);
      expect_eq("iwrap_a1", iw_a[1], 32'h000);
      expect_eq("iwrap_d1", iw_d[1], 32'hBB);
    end
    clear_logs();

    frame = '{8'h01, 8'h00, 8'h10, 8'h00, 8'h00};
    send_frame(1'b0);
    idle(3);
    expect_eq("len0_no_write", 32'(iw_a.size()), 0);
    expect_eq("len0_idle", 32'(busy), 0);

    frame = '{8'h01, 8'h00, 8'h20, 8'h00, 8'h04, 8'h11, 8'h22};
    send_frame(1'b0);
    idle(1);
    rst_n = 1'b0;
    @(negedge clk);
    expect_eq("midrst_s_ready", 32'(s_ready), 1);
    expect_eq("midrst_busy", 32'(busy), 0);
    expect_eq("midrst_imem_we", 32'(imem_we), 0);
    rst_n = 1'b1;
    idle(4);
    expect_eq("midrst_writes", 32'(iw_a.size()), 2);
    clear_logs();
    frame = '{8'h01, 8'h00, 8'h30, 8'h00, 8'h01, 8'h5A};
    send_frame(1'b0);
    idle(3);
    expect_eq("fresh_count", 32'(iw_a.size()), 1);
    if (iw_a.size() == 1) begin
      expect_eq("fresh_addr", iw_a[0], 32'h030);
      expect_eq("fresh_data", iw_d[0], 32'h5A);
    end
    clear_logs();

    abort = 1'b1;
    idle(2);
    abort = 1'b0;
    expect_eq("abort_idle_busy", 32'(busy), 0);
    expect_eq("abort_idle_done", 32'(run_done), 0);

    frame = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h19};
    send_frame(1'b0);
    expect_eq("run_start_rise", 32'(core_start), 1);
    run_watch(0, 1'b0, 1'b0);
    expect_eq("to_hi_cycles", 32'(hi_cnt), 25);
    expect_eq("to_halted", 32'(run_halted), 0);
    expect_eq("to_count", cycle_count, 25);
    expect_eq("to_ready_low", 32'(ready_seen), 0);
    @(negedge clk);
    expect_eq("to_done_pulse", 32'(run_done), 0);
    expect_eq("to_count_hold", cycle_count, 25);

    frame = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    run_watch(7, 1'b1, 1'b0);
    expect_eq("halt_hi_cycles", 32'(hi_cnt), 7);
    expect_eq("halt_halted", 32'(run_halted), 1);
    expect_eq("halt_count", cycle_count, 7);
    idle(1);

    send_frame(1'b0);
    run_watch(7, 1'b1, 1'b1);
    expect_eq("halt_abort_hi", 32'(hi_cnt), 7);
    expect_eq("halt_abort_halted", 32'(run_halted), 1);
    idle(1);

    send_frame(1'b0);
    run_watch(4, 1'b0, 1'b1);
    expect_eq("abort_hi", 32'(hi_cnt), 4);
    expect_eq("abort_halted", 32'(run_halted), 0);
    expect_eq("abort_count", cycle_count, 4);
    idle(1);

    frame = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h05};
    send_frame(1'b0);
    run_watch(5, 1'b1, 1'b0);
    expect_eq("halt_vs_to_hi", 32'(hi_cnt), 5);
    expect_eq("halt_vs_to_halted", 32'(run_halted), 1);
    expect_eq("halt_vs_to_count", cycle_count, 5);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
